doodle_motion_ctrl: RTL and testbench



---
 rtl/doodle_pkg.sv | 31 +++
 rtl/grav_ticker.sv | 40 ++++
 rtl/doodle_motion_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_doodle_motion_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// Shared types and constants for the doodle motion controller.
// Holds the motion state encoding, key codes and screen geometry.
package doodle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2,
        DEAD = 2'd3
    } motion_state_t;

    localparam logic [7:0] KEY_RIGHT_A = 8'd7;
    localparam logic [7:0] KEY_RIGHT_B = 8'd79;
    localparam logic [7:0] KEY_LEFT_A  = 8'd4;
    localparam logic [7:0] KEY_LEFT_B  = 8'd80;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [9:0] SPAWN_X = 10'd320;
    localparam logic [9:0] SPAWN_Y = 10'd240;

    function automatic logic key_right(input logic [7:0] k);
        return (k == KEY_RIGHT_A) || (k == KEY_RIGHT_B);
    endfunction

    function automatic logic key_left(input logic [7:0] k);
        return (k == KEY_LEFT_A) || (k == KEY_LEFT_B);
    endfunction

endpackage

// File: rtl/grav_ticker.sv
// Frame counter modulo DIV; tick marks the frame on which gravity
// adds one to the vertical velocity. clr restarts the count.
module grav_ticker #(
    parameter int DIV = 4
) (
    input  logic frame_clk,
    input  logic Reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = en && !clr && (cnt_q == LAST);

    // Next count: clear wins, otherwise wrap at LAST while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/doodle_motion_ctrl.sv
// Per-frame motion sequencer for the doodle: jump state machine,
// gravity, steering with wrap, landing, scroll requests and death.
module doodle_motion_ctrl
    import doodle_pkg::*;
#(
    parameter int SCREEN_Y_MAX = 479,
    parameter int DOODLE_SIZE  = 12,
    parameter int JUMP_VEL     = 10,
    parameter int GRAV_DIV     = 4,
    parameter int MAX_FALL     = 8,
    parameter int SCROLL_LINE  = 160,
    parameter int X_MIN        = 25,
    parameter int X_MAX        = 614,
    parameter int X_STEP       = 2
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [7:0]  keycode,
    input  logic        plat_hit,
    input  logic [9:0]  plat_top,
    output logic [9:0]  doodle_x,
    output logic [9:0]  doodle_y,
    output logic [9:0]  y_vel,
    output logic        scroll_en,
    output logic [3:0]  scroll_amt,
    output logic        loadplat,
    output logic        game_over,
    output logic [1:0]  state
);

    localparam logic signed [10:0] SCROLL_S = 11'(SCROLL_LINE);
    localparam logic signed [10:0] DEATH_S  = 11'(SCREEN_Y_MAX - DOODLE_SIZE);
    localparam logic signed [10:0] XMIN_S   = 11'(X_MIN);
    localparam logic signed [10:0] XMAX_S   = 11'(X_MAX);
    localparam logic signed [10:0] STEP_S   = 11'(X_STEP);
    localparam logic signed [9:0]  VEL_JUMP = 10'(-JUMP_VEL);
    localparam logic signed [9:0]  VEL_MAX  = 10'(MAX_FALL);
    localparam logic [9:0]         HALF_H   = 10'(DOODLE_SIZE);
    localparam logic [9:0]         SCROLL_Y = 10'(SCROLL_LINE);
    localparam logic [9:0]         DEAD_Y   = 10'(SCREEN_Y_MAX - DOODLE_SIZE);
    localparam logic [9:0]         XMIN_Q   = 10'(X_MIN);
    localparam logic [9:0]         XMAX_Q   = 10'(X_MAX);

    motion_state_t      state_q;
    motion_state_t      state_d;
    logic [9:0]         x_q;
    logic [9:0]         x_d;
    logic [9:0]         y_q;
    logic [9:0]         y_d;
    logic signed [9:0]  vel_q;
    logic signed [9:0]  vel_d;
    logic               scroll_en_q;
    logic               scroll_en_d;
    logic [3:0]         scroll_amt_q;
    logic [3:0]         scroll_amt_d;
    logic               loadplat_q;
    logic               loadplat_d;
    logic               game_over_q;
    logic               game_over_d;

    logic signed [10:0] ny;
    logic signed [10:0] nx;
    logic signed [10:0] dx;
    logic [9:0]         wx;
    logic signed [9:0]  vel_inc;
    logic               launch;
    logic               tk_en;
    logic               tk_clr;
    logic               tick;

    grav_ticker #(
        .DIV (GRAV_DIV)
    ) u_grav (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .en        (tk_en),
        .clr       (tk_clr),
        .tick      (tick)
    );

    // Candidate vertical/horizontal positions before state overrides
    always_comb begin
        ny      = $signed({1'b0, y_q}) + $signed({vel_q[9], vel_q});
        vel_inc = vel_q + 10'sd1;
        dx      = '0;
        unique case (1'b1)
            key_right(keycode): dx = STEP_S;
            key_left(keycode):  dx = -STEP_S;
            default:            dx = '0;
        endcase
        nx = $signed({1'b0, x_q}) + dx;
        if (nx > XMAX_S) begin
            wx = XMIN_Q;
        end else if (nx < XMIN_S) begin
            wx = XMAX_Q;
        end else begin
            wx = nx[9:0];
        end
    end

    // Jump state machine and next-frame motion registers
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        vel_d        = vel_q;
        scroll_en_d  = 1'b0;
        scroll_amt_d = '0;
        loadplat_d   = 1'b0;
        launch       = 1'b0;
        tk_en        = 1'b0;
        tk_clr       = 1'b0;
        unique case (state_q)
            IDLE: begin
                x_d    = SPAWN_X;
                y_d    = SPAWN_Y;
                launch = start;
            end
            RISE: begin
                tk_en = 1'b1;
                x_d   = wx;
                if (ny < SCROLL_S) begin
                    y_d          = SCROLL_Y;
                    scroll_en_d  = 1'b1;
                    scroll_amt_d = 4'(SCROLL_S - ny);
                end else begin
                    y_d = ny[9:0];
                end
                if (tick) begin
                    vel_d = vel_inc;
                    if (vel_inc == 10'sd0) begin
                        state_d = FALL;
                    end
                end
            end
            FALL: begin
                tk_en = 1'b1;
                x_d   = wx;
                if (plat_hit) begin
                    y_d     = plat_top - HALF_H;
                    vel_d   = VEL_JUMP;
                    tk_clr  = 1'b1;
                    state_d = RISE;
                end else if (ny >= DEATH_S) begin
                    y_d     = DEAD_Y;
                    vel_d   = '0;
                    state_d = DEAD;
                end else begin
                    y_d = ny[9:0];
                    if (tick) begin
                        vel_d = (vel_q >= VEL_MAX) ? VEL_MAX : vel_inc;
                    end
                end
            end
            DEAD: begin
                vel_d  = '0;
                launch = start;
            end
        endcase
        if (launch) begin
            x_d        = SPAWN_X;
            y_d        = SPAWN_Y;
            vel_d      = VEL_JUMP;
            tk_clr     = 1'b1;
            loadplat_d = 1'b1;
            state_d    = RISE;
        end
        game_over_d = (state_d == DEAD);
    end

    // Frame register bank; Reset returns to the spawn point in IDLE
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            x_q          <= SPAWN_X;
            y_q          <= SPAWN_Y;
            vel_q        <= '0;
            scroll_en_q  <= 1'b0;
            scroll_amt_q <= '0;
            loadplat_q   <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            vel_q        <= vel_d;
            scroll_en_q  <= scroll_en_d;
            scroll_amt_q <= scroll_amt_d;
            loadplat_q   <= loadplat_d;
            game_over_q  <= game_over_d;
        end
    end

    assign doodle_x   = x_q;
    assign doodle_y   = y_q;
    assign y_vel      = vel_q;
    assign scroll_en  = scroll_en_q;
    assign scroll_amt = scroll_amt_q;
    assign loadplat   = loadplat_q;
    assign game_over  = game_over_q;
    assign state      = state_q;

endmodule

// File: tb/tb_doodle_motion_ctrl.sv
// Bench for doodle_motion_ctrl: directed scenarios plus random play,
// every frame compared with an integer model of the motion rules.
module tb_doodle_motion_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       start;
    logic [7:0] keycode;
    logic       plat_hit;
    logic [9:0] plat_top;
    logic [9:0] doodle_x;
    logic [9:0] doodle_y;
    logic [9:0] y_vel;
    logic       scroll_en;
    logic [3:0] scroll_amt;
    logic       loadplat;
    logic       game_over;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    int m_st, m_x, m_y, m_v, m_cnt, m_sc, m_amt, m_ld, m_go;

    localparam logic [38:0] RST_VEC =
        {10'd320, 10'd240, 10'd0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0};

    logic [38:0] dut_vec;
    assign dut_vec = {doodle_x, doodle_y, y_vel, scroll_en,
                      scroll_amt, loadplat, game_over, state};

    doodle_motion_ctrl dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .start      (start),
        .keycode    (keycode),
        .plat_hit   (plat_hit),
        .plat_top   (plat_top),
        .doodle_x   (doodle_x),
        .doodle_y   (doodle_y),
        .y_vel      (y_vel),
        .scroll_en  (scroll_en),
        .scroll_amt (scroll_amt),
        .loadplat   (loadplat),
        .game_over  (game_over),
        .state      (state)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic logic [38:0] exp_vec();
        return {10'(m_x), 10'(m_y), 10'(m_v), 1'(m_sc),
                4'(m_amt), 1'(m_ld), 1'(m_go), 2'(m_st)};
    endfunction

    task automatic m_reset();
        m_st = 0; m_x = 320; m_y = 240; m_v = 0; m_cnt = 0;
        m_sc = 0; m_amt = 0; m_ld = 0; m_go = 0;
    endtask

    // Behavioural model: one frame of the game rules in plain integers
    task automatic m_step(input bit st, input logic [7:0] key,
                          input bit hit, input logic [9:0] top);
        int ny, nx, dx;
        m_sc = 0; m_amt = 0; m_ld = 0;
        dx = (key == 7 || key == 79) ? 2 : (key == 4 || key == 80) ? -2 : 0;
        nx = m_x + dx;
        if (nx > 614) nx = 25;
        else if (nx < 25) nx = 614;
        ny = m_y + m_v;
        case (m_st)
            1: begin
                m_x = nx;
                if (ny < 160) begin
                    m_y = 160; m_sc = 1; m_amt = 160 - ny;
                end else begin
                    m_y = ny;
                end
                if (m_cnt == 3) begin
                    m_cnt = 0; m_v = m_v + 1;
                    if (m_v == 0) m_st = 2;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            2: begin
                m_x = nx;
                if (hit) begin
                    m_y = int'(top) - 12; m_v = -10; m_cnt = 0; m_st = 1;
                end else if (ny + 12 >= 479) begin
                    m_y = 467; m_v = 0; m_st = 3;
                end else begin
                    m_y = ny;
                    if (m_cnt == 3) begin
                        m_cnt = 0;
                        if (m_v < 8) m_v = m_v + 1;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
            end
            default: begin
                if (m_st == 3) m_v = 0;
                if (st) begin
                    m_x = 320; m_y = 240; m_v = -10; m_cnt = 0;
                    m_ld = 1; m_st = 1;
                end
            end
        endcase
        m_go = (m_st == 3) ? 1 : 0;
    endtask

    // Drive one frame, advance DUT and model together, return at negedge
    task automatic step(input bit st, input logic [7:0] key,
                        input bit hit, input logic [9:0] top);
        start = st; keycode = key; plat_hit = hit; plat_top = top;
        @(posedge frame_clk);
        m_step(st, key, hit, top);
        @(negedge frame_clk);
    endtask

    task automatic assert_reset_async();
        #2 Reset = 1'b1;
        m_reset();
        #1;
    endtask

    task automatic release_reset();
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; start = 0; keycode = 0; plat_hit = 0; plat_top = 0;
        m_reset();
        @(negedge frame_clk);
        checks++;
        if (dut_vec !== RST_VEC) begin
            errors++;
            $display("FAIL reset_vec got=%h want=%h", dut_vec, RST_VEC);
        end
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(0, 8'd7, 1, 10'd300);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL idle_hold got=%h want=%h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_launch_climb();
        int ys[8] = '{230, 220, 210, 200, 191, 182, 173, 164};
        step(1, 8'd0, 0, 10'd0);
        checks++;
        if ({loadplat, state, y_vel, doodle_y} !== {1'b1, 2'd1, 10'h3F6, 10'd240}) begin
            errors++;
            $display("FAIL launch got=%b/%0d/%h/%0d want=1/1/3f6/240",
                     loadplat, state, y_vel, doodle_y);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 8'd0, 0, 10'd0);
            checks++;
            if (doodle_y !== 10'(ys[i]) || loadplat !== 1'b0 || scroll_en !== 1'b0) begin
                errors++;
                $display("FAIL climb_%0d got y=%0d ld=%b sc=%b want y=%0d ld=0 sc=0",
                         i, doodle_y, loadplat, scroll_en, ys[i]);
            end
        end
        step(0, 8'd0, 0, 10'd0);
        checks++;
        if ({doodle_y, scroll_en, scroll_amt} !== {10'd160, 1'b1, 4'd4}) begin
            errors++;
            $display("FAIL scroll9 got y=%0d en=%b amt=%0d want 160/1/4",
                     doodle_y, scroll_en, scroll_amt);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL climb_model got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_fall_land();
        int n = 0;
        while (m_st != 2 && n < 100) begin
            step(0, 8'd0, 1, 10'd200);
            n++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL rise_to_fall got=%h want=%h", dut_vec, exp_vec());
            end
        end
        checks++;
        if (m_st != 2) begin
            errors++;
            $display("FAIL fall_timeout got state=%0d want 2", state);
        end
        step(0, 8'd0, 1, 10'd300);
        checks++;
        if ({doodle_y, y_vel, state} !== {10'd288, 10'h3F6, 2'd1}) begin
            errors++;
            $display("FAIL land got y=%0d v=%h st=%0d want 288/3f6/1",
                     doodle_y, y_vel, state);
        end
    endtask

    task automatic test_death();
        int n = 0;
        while (m_st != 3 && n < 300) begin
            step(0, 8'd0, 0, 10'd0);
            n++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL to_death got=%h want=%h", dut_vec, exp_vec());
            end
        end
        checks++;
        if ({doodle_y, y_vel, game_over, state} !== {10'd467, 10'd0, 1'b1, 2'd3}) begin
            errors++;
            $display("FAIL death got y=%0d v=%h go=%b st=%0d want 467/0/1/3",
                     doodle_y, y_vel, game_over, state);
        end
        step(0, 8'd7, 1, 10'd300);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL dead_hold got=%h want=%h", dut_vec, exp_vec());
        end
        step(1, 8'd0, 0, 10'd0);
        checks++;
        if ({doodle_x, doodle_y, state, loadplat, game_over} !==
            {10'd320, 10'd240, 2'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL restart got x=%0d y=%0d st=%0d ld=%b go=%b want 320/240/1/1/0",
                     doodle_x, doodle_y, state, loadplat, game_over);
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        while (m_x != 613 && n < 1000) begin
            step(0, 8'd7, (m_st == 2), 10'(m_y + 12));
            n++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL sweep_right got=%h want=%h", dut_vec, exp_vec());
            end
        end
        step(0, 8'd7, (m_st == 2), 10'(m_y + 12));
        checks++;
        if (doodle_x !== 10'd25) begin
            errors++;
            $display("FAIL wrap_right got x=%0d want 25", doodle_x);
        end
        n = 0;
        while (m_x != 26 && n < 1000) begin
            step(0, 8'd80, (m_st == 2), 10'(m_y + 12));
            n++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL sweep_left got=%h want=%h", dut_vec, exp_vec());
            end
        end
        step(0, 8'd80, (m_st == 2), 10'(m_y + 12));
        checks++;
        if (doodle_x !== 10'd614) begin
            errors++;
            $display("FAIL wrap_left got x=%0d want 614", doodle_x);
        end
        step(0, 8'd0, (m_st == 2), 10'(m_y + 12));
        checks++;
        if (doodle_x !== 10'd614) begin
            errors++;
            $display("FAIL no_key got x=%0d want 614", doodle_x);
        end
    endtask

    task automatic test_reset_midflight();
        if (m_st == 2) step(0, 8'd0, 1, 10'(m_y + 12));
        for (int i = 0; i < 2; i++) begin
            step(1, 8'd4, 1, 10'd400);
            checks++;
            if (dut_vec !== exp_vec() || loadplat !== 1'b0) begin
                errors++;
                $display("FAIL rise_ignore got=%h want=%h", dut_vec, exp_vec());
            end
        end
        assert_reset_async();
        checks++;
        if (dut_vec !== RST_VEC) begin
            errors++;
            $display("FAIL midflight_reset got=%h want=%h", dut_vec, RST_VEC);
        end
        release_reset();
        start = 0;
        step(0, 8'd0, 0, 10'd0);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL post_reset got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [7:0] k;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                assert_reset_async();
                checks++;
                if (dut_vec !== RST_VEC) begin
                    errors++;
                    $display("FAIL rand_reset got=%h want=%h", dut_vec, RST_VEC);
                end
                release_reset();
            end
            case ($urandom_range(0, 5))
                0: k = 8'd0;
                1: k = 8'd7;
                2: k = 8'd79;
                3: k = 8'd4;
                4: k = 8'd80;
                default: k = 8'($urandom);
            endcase
            step($urandom_range(0, 15) == 0, k, $urandom_range(0, 2) == 0,
                 10'($urandom_range(172, 478)));
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL rand_%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_launch_climb();
        test_fall_land();
        test_death();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
